// File: rtl/result_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : result_writeback_if
//  Description : Request/result-element inputs and RAM write-port outputs of
//                the 2x2 result writeback engine, with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface result_writeback_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  // Request side
  logic              start_i;
  logic [ADDR_W-1:0] result_baseaddr_i;
  logic              transpose_i;
  logic [DATA_W-1:0] c11_i;
  logic [DATA_W-1:0] c12_i;
  logic [DATA_W-1:0] c21_i;
  logic [DATA_W-1:0] c22_i;
  // RAM write port and status
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic              we_o;
  logic              busy_o;
  logic              done_o;

  // Writeback engine view
  modport slave (
    input  start_i, result_baseaddr_i, transpose_i, c11_i, c12_i, c21_i, c22_i,
    output addr_o, data_o, we_o, busy_o, done_o
  );

  // Requester / RAM view
  modport master (
    output start_i, result_baseaddr_i, transpose_i, c11_i, c12_i, c21_i, c22_i,
    input  addr_o, data_o, we_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/result_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : result_writeback
//  Description : Writes a latched 2x2 result block into a single-port RAM as
//                four consecutive words (row- or column-major), then pulses
//                done. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_writeback #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  result_writeback_if.slave wb_if
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              tr_q, tr_d;
  logic [DATA_W-1:0] c11_q, c11_d, c12_q, c12_d, c21_q, c21_d, c22_q, c22_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        k_nxt_w;
  logic [DATA_W-1:0] pick_w;

  assign k_nxt_w = k_q + 2'd1;

  // Element for the next write slot; transpose swaps the two off-diagonal words.
  always_comb begin
    case (k_nxt_w)
      2'd1:    pick_w = tr_q ? c21_q : c12_q;
      2'd2:    pick_w = tr_q ? c12_q : c21_q;
      2'd3:    pick_w = c22_q;
      default: pick_w = c11_q;
    endcase
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // they can be registered.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    tr_d    = tr_q;
    c11_d   = c11_q;
    c12_d   = c12_q;
    c21_d   = c21_q;
    c22_d   = c22_q;
    addr_d  = base_q;
    data_d  = '0;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_if.start_i) begin
          // Latch the whole request; first word (c11 at base) goes out next cycle.
          base_d  = wb_if.result_baseaddr_i;
          tr_d    = wb_if.transpose_i;
          c11_d   = wb_if.c11_i;
          c12_d   = wb_if.c12_i;
          c21_d   = wb_if.c21_i;
          c22_d   = wb_if.c22_i;
          state_d = S_WRITE;
          k_d     = 2'd0;
          addr_d  = wb_if.result_baseaddr_i;
          data_d  = wb_if.c11_i;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_WRITE: begin
        if (k_q == 2'd3) begin
          state_d = S_DONE;
          k_d     = 2'd0;
          done_d  = 1'b1;
        end else begin
          // Address wraps naturally modulo 2^ADDR_W.
          k_d    = k_nxt_w;
          addr_d = base_q + ADDR_W'(k_nxt_w);
          data_d = pick_w;
          we_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = 2'd0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = 2'd0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      base_q  <= '0;
      tr_q    <= 1'b0;
      c11_q   <= '0;
      c12_q   <= '0;
      c21_q   <= '0;
      c22_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      tr_q    <= tr_d;
      c11_q   <= c11_d;
      c12_q   <= c12_d;
      c21_q   <= c21_d;
      c22_q   <= c22_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wb_if.addr_o = addr_q;
  assign wb_if.data_o = data_q;
  assign wb_if.we_o   = we_q;
  assign wb_if.busy_o = busy_q;
  assign wb_if.done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_result_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_writeback
//  Description : Self-checking bench for result_writeback: a schedule-based
//                reference model compared every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_writeback;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
  } rec_t;

  logic clk;
  logic rst;
  int   n_tot;
  int   n_bad;

  result_writeback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wbi ();

  result_writeback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb_if (wbi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an accepted request schedules its whole future output
  // trace (4 writes, a done cycle, an idle cycle in which start is ignored).
  rec_t q_m[$];
  rec_t exp_m;
  int   base_m;
  bit   live_m;

  function automatic rec_t mk(input logic w, input int a, input int d,
                              input logic b, input logic dn);
    rec_t r;
    r.we   = w;
    r.addr = ADDR_W'(a);
    r.data = DATA_W'(d);
    r.busy = b;
    r.done = dn;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q_m.delete();
      base_m = 0;
      live_m = 1'b1;
      exp_m  = mk(1'b0, 0, 0, 1'b0, 1'b0);
    end else begin
      if (q_m.size() == 0 && wbi.start_i === 1'b1) begin
        int el [2][2];
        el[0][0] = int'(wbi.c11_i);
        el[0][1] = int'(wbi.c12_i);
        el[1][0] = int'(wbi.c21_i);
        el[1][1] = int'(wbi.c22_i);
        base_m = int'(wbi.result_baseaddr_i);
        for (int k = 0; k < 4; k++) begin
          int d;
          d = wbi.transpose_i ? el[k % 2][k / 2] : el[k / 2][k % 2];
          q_m.push_back(mk(1'b1, (base_m + k) % (1 << ADDR_W), d, 1'b1, 1'b0));
        end
        q_m.push_back(mk(1'b0, base_m, 0, 1'b0, 1'b1));
        q_m.push_back(mk(1'b0, base_m, 0, 1'b0, 1'b0));
      end
      if (q_m.size() > 0) exp_m = q_m.pop_front();
      else                exp_m = mk(1'b0, base_m, 0, 1'b0, 1'b0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  // One clock; outputs are compared against the model on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (live_m) begin
      chk("model_we",   32'(wbi.we_o),   32'(exp_m.we));
      chk("model_addr", 32'(wbi.addr_o), 32'(exp_m.addr));
      chk("model_data", 32'(wbi.data_o), 32'(exp_m.data));
      chk("model_busy", 32'(wbi.busy_o), 32'(exp_m.busy));
      chk("model_done", 32'(wbi.done_o), 32'(exp_m.done));
    end
  endtask

  task automatic req(input logic [ADDR_W-1:0] b, input logic t,
                     input logic [DATA_W-1:0] x11, input logic [DATA_W-1:0] x12,
                     input logic [DATA_W-1:0] x21, input logic [DATA_W-1:0] x22);
    wbi.start_i           = 1'b1;
    wbi.result_baseaddr_i = b;
    wbi.transpose_i       = t;
    wbi.c11_i             = x11;
    wbi.c12_i             = x12;
    wbi.c21_i             = x21;
    wbi.c22_i             = x22;
  endtask

  // Drop start and scramble the request inputs; latched values must not move.
  task automatic scramble();
    wbi.start_i           = 1'b0;
    wbi.result_baseaddr_i = ADDR_W'($urandom);
    wbi.transpose_i       = 1'($urandom);
    wbi.c11_i             = DATA_W'($urandom);
    wbi.c12_i             = DATA_W'($urandom);
    wbi.c21_i             = DATA_W'($urandom);
    wbi.c22_i             = DATA_W'($urandom);
  endtask

  task automatic chk_w(input string nm, input int ea, input int ed);
    cyc();
    chk({nm, "_we"},   32'(wbi.we_o),   32'd1);
    chk({nm, "_addr"}, 32'(wbi.addr_o), 32'(ea));
    chk({nm, "_data"}, 32'(wbi.data_o), 32'(ed));
  endtask

  task automatic chk_done(input string nm);
    cyc();
    chk({nm, "_done"}, 32'(wbi.done_o), 32'd1);
    chk({nm, "_we"},   32'(wbi.we_o),   32'd0);
    chk({nm, "_busy"}, 32'(wbi.busy_o), 32'd0);
  endtask

  initial begin
    n_tot  = 0;
    n_bad  = 0;
    live_m = 1'b0;
    rst    = 1'b1;
    req(6'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    wbi.start_i = 1'b1;  // reset must override start
    cyc();
    cyc();
    chk("rst_we",   32'(wbi.we_o),   32'd0);
    chk("rst_busy", 32'(wbi.busy_o), 32'd0);
    chk("rst_done", 32'(wbi.done_o), 32'd0);
    chk("rst_addr", 32'(wbi.addr_o), 32'd0);
    chk("rst_data", 32'(wbi.data_o), 32'd0);
    rst = 1'b0;
    wbi.start_i = 1'b0;
    cyc();

    // Row-major block at 0x10
    req(6'h10, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
    chk_w("row_w0", 'h10, 'h01);
    chk("row_busy", 32'(wbi.busy_o), 32'd1);
    scramble();
    chk_w("row_w1", 'h11, 'h02);
    chk_w("row_w2", 'h12, 'h03);
    chk_w("row_w3", 'h13, 'h04);
    chk_done("row");
    cyc();
    chk("row_idle_addr", 32'(wbi.addr_o), 32'h10);
    chk("row_idle_done", 32'(wbi.done_o), 32'd0);
    cyc();

    // Column-major block at 0x10
    req(6'h10, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
    chk_w("col_w0", 'h10, 'h01);
    scramble();
    chk_w("col_w1", 'h11, 'h03);
    chk_w("col_w2", 'h12, 'h02);
    chk_w("col_w3", 'h13, 'h04);
    chk_done("col");
    cyc();
    cyc();

    // Address wrap from 0x3F to 0x00
    req(6'h3E, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
    chk_w("wrap_w0", 'h3E, 'h11);
    scramble();
    chk_w("wrap_w1", 'h3F, 'h22);
    chk_w("wrap_w2", 'h00, 'h33);
    chk_w("wrap_w3", 'h01, 'h44);
    chk_done("wrap");
    cyc();

    // start re-pulsed during WRITE with 0xFF elements: ignored
    req(6'h20, 1'b0, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    chk_w("ign_w0", 'h20, 'hA1);
    req(6'h05, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    chk_w("ign_w1", 'h21, 'hA2);
    chk_w("ign_w2", 'h22, 'hA3);
    chk_w("ign_w3", 'h23, 'hA4);
    wbi.start_i = 1'b0;
    chk_done("ign");

    // start held over the DONE cycle (ignored) and the following IDLE cycle
    // (accepted): back-to-back blocks, 6 cycles apart
    req(6'h08, 1'b1, 8'h5A, 8'h6B, 8'h7C, 8'h8D);
    cyc();
    chk("b2b_gap_we",   32'(wbi.we_o),   32'd0);
    chk("b2b_gap_done", 32'(wbi.done_o), 32'd0);
    chk_w("b2b_w0", 'h08, 'h5A);
    scramble();
    chk_w("b2b_w1", 'h09, 'h7C);
    chk_w("b2b_w2", 'h0A, 'h6B);
    chk_w("b2b_w3", 'h0B, 'h8D);
    chk_done("b2b");
    cyc();

    // Reset on the second write cycle aborts the block without done
    req(6'h30, 1'b0, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    chk_w("abort_w0", 'h30, 'hC1);
    scramble();
    rst = 1'b1;
    cyc();
    chk("abort_we",   32'(wbi.we_o),   32'd0);
    chk("abort_busy", 32'(wbi.busy_o), 32'd0);
    chk("abort_addr", 32'(wbi.addr_o), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("abort_nodone", 32'(wbi.done_o), 32'd0);
      chk("abort_nowe",   32'(wbi.we_o),   32'd0);
    end

    // Normal operation after the aborted block
    req(6'h31, 1'b1, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
    chk_w("post_w0", 'h31, 'hD1);
    scramble();
    chk_w("post_w1", 'h32, 'hD3);
    chk_w("post_w2", 'h33, 'hD2);
    chk_w("post_w3", 'h34, 'hD4);
    chk_done("post");
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
